// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter: FSM state encoding,
// parity mode codes and the idle level of the serial line.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity bit generator: with mode=0 (even) the returned bit makes the total
// number of ones in data plus parity even; with mode=1 (odd) it makes it odd.
module parity_calc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic              parity
);

  function automatic logic xor_parity(input logic [DATA_W-1:0] d, input logic m);
    return (^d) ^ m;
  endfunction

  assign parity = xor_parity(data, mode);

endmodule

// File: rtl/parity_tx_ctrl.sv
// Serial frame transmitter: accepts one word over valid/ready and sends
// start(0), data LSB first, parity, stop(1), each bit held CLKS_PER_BIT clocks.
// Optional build macro PARITY_TX_FRAME_CNT_EN adds a 16-bit completed-frame
// counter output (frame_cnt) that wraps at 0xFFFF.
module parity_tx_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              par_mode,
  output logic              tx,
  output logic              busy,
  output logic              done
`ifdef PARITY_TX_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_ZERO = TW'(0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);

  tx_state_e         state_r, next_state_s;
  logic [TW-1:0]     tick_r, next_tick_s;
  logic [BW-1:0]     bit_idx_r, next_bit_s;
  logic [DATA_W-1:0] data_r;
  logic              mode_r;
  logic              par_s;
  logic              accept_s;
  logic              tick_wrap_s;
  logic              tx_s, busy_s, done_s;
  logic              tx_r, busy_r, done_r;

  // Parity always follows the latched word and mode, so it is stable all frame.
  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data   (data_r),
    .mode   (mode_r),
    .parity (par_s)
  );

  assign in_ready = (state_r == IDLE) & ~rst;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Next-state, bit/tick sequencing and next values of the registered outputs.
  always_comb begin
    next_state_s = state_r;
    next_tick_s  = tick_r;
    next_bit_s   = bit_idx_r;
    accept_s     = 1'b0;
    tick_wrap_s  = (tick_r == TICK_LAST);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = START;
          next_tick_s  = TICK_ZERO;
          next_bit_s   = BIT_ZERO;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (tick_wrap_s) begin
          next_state_s = DATA;
          next_tick_s  = TICK_ZERO;
          next_bit_s   = BIT_ZERO;
        end else begin
          next_tick_s = tick_r + TICK_ONE;
        end
      end
      DATA: begin
        if (tick_wrap_s) begin
          next_tick_s = TICK_ZERO;
          if (bit_idx_r == BIT_LAST) begin
            next_state_s = PARITY;
            next_bit_s   = BIT_ZERO;
          end else begin
            next_bit_s = bit_idx_r + BIT_ONE;
          end
        end else begin
          next_tick_s = tick_r + TICK_ONE;
        end
      end
      PARITY: begin
        if (tick_wrap_s) begin
          next_state_s = STOP;
          next_tick_s  = TICK_ZERO;
        end else begin
          next_tick_s = tick_r + TICK_ONE;
        end
      end
      STOP: begin
        if (tick_wrap_s) begin
          next_state_s = IDLE;
          next_tick_s  = TICK_ZERO;
        end else begin
          next_tick_s = tick_r + TICK_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_tick_s  = TICK_ZERO;
        next_bit_s   = BIT_ZERO;
      end
    endcase

    // tx is registered, so it is decoded from the state being entered.
    case (next_state_s)
      IDLE:    tx_s = TX_IDLE_LVL;
      START:   tx_s = 1'b0;
      DATA:    tx_s = data_r[next_bit_s];
      PARITY:  tx_s = par_s;
      STOP:    tx_s = TX_IDLE_LVL;
      default: tx_s = TX_IDLE_LVL;
    endcase

    busy_s = (next_state_s != IDLE);
    done_s = (state_r == STOP) && (next_state_s == IDLE);
  end

  // State, counters, latched payload and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      tick_r    <= TICK_ZERO;
      bit_idx_r <= BIT_ZERO;
      data_r    <= {DATA_W{1'b0}};
      mode_r    <= PAR_EVEN;
      tx_r      <= TX_IDLE_LVL;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      tick_r    <= next_tick_s;
      bit_idx_r <= next_bit_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      if (accept_s) begin
        data_r <= in_data;
        mode_r <= par_mode;
      end
    end
  end

`ifdef PARITY_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  assign frame_cnt = frame_cnt_r;

  // Count completed frames; updates together with the done pulse and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 16'h0000;
    end else if (done_s) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end
  end
`endif

endmodule
